// File: rtl/tft_ctrl.sv
// 480x272 TFT timing controller: scan counters, sync/DE decode, and a coordinate request
// issued one clock ahead so the downstream pattern register lines up with tft_de.
module tft_ctrl #(
  parameter logic [9:0] H_SYNC  = 10'd41,
  parameter logic [9:0] H_BACK  = 10'd2,
  parameter logic [9:0] H_VALID = 10'd480,
  parameter logic [9:0] H_FRONT = 10'd2,
  parameter logic [9:0] H_TOTAL = 10'd525,
  parameter logic [9:0] V_SYNC  = 10'd10,
  parameter logic [9:0] V_BACK  = 10'd2,
  parameter logic [9:0] V_VALID = 10'd272,
  parameter logic [9:0] V_FRONT = 10'd2,
  parameter logic [9:0] V_TOTAL = 10'd286
) (
  input  logic        clk_9m,
  input  logic        sys_rst_n,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [15:0] rgb_tft,
  output logic        hsync,
  output logic        vsync,
  output logic        tft_clk,
  output logic        tft_de,
  output logic        tft_bl
);

  if (H_TOTAL != H_SYNC + H_BACK + H_VALID + H_FRONT) begin : g_bad_h_total
    $error("H_TOTAL does not match the sum of the horizontal segments");
  end
  if (V_TOTAL != V_SYNC + V_BACK + V_VALID + V_FRONT) begin : g_bad_v_total
    $error("V_TOTAL does not match the sum of the vertical segments");
  end

  localparam logic [9:0] HActStart = H_SYNC + H_BACK;
  localparam logic [9:0] HActEnd   = H_SYNC + H_BACK + H_VALID - 10'd1;
  localparam logic [9:0] HReqStart = HActStart - 10'd1;
  localparam logic [9:0] HReqEnd   = HActEnd - 10'd1;
  localparam logic [9:0] VActStart = V_SYNC + V_BACK;
  localparam logic [9:0] VActEnd   = V_SYNC + V_BACK + V_VALID - 10'd1;
  localparam logic [9:0] HLast     = H_TOTAL - 10'd1;
  localparam logic [9:0] VLast     = V_TOTAL - 10'd1;

  logic [9:0] cnt_h_q, cnt_h_d;
  logic [9:0] cnt_v_q, cnt_v_d;
  logic       h_end, v_end;
  logic       h_act, v_act, pix_req;

  // >= rather than == so a corrupted counter still falls back to 0 at the terminal count.
  always_comb begin
    h_end   = (cnt_h_q >= HLast);
    v_end   = (cnt_v_q >= VLast);
    cnt_h_d = h_end ? 10'd0 : cnt_h_q + 10'd1;
    cnt_v_d = cnt_v_q;
    if (h_end) begin
      cnt_v_d = v_end ? 10'd0 : cnt_v_q + 10'd1;
    end
  end

  always_ff @(posedge clk_9m or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h_q <= 10'd0;
      cnt_v_q <= 10'd0;
    end else begin
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
    end
  end

  always_comb begin
    hsync   = (cnt_h_q <= H_SYNC - 10'd1);
    vsync   = (cnt_v_q <= V_SYNC - 10'd1);
    h_act   = (cnt_h_q >= HActStart) && (cnt_h_q <= HActEnd);
    v_act   = (cnt_v_q >= VActStart) && (cnt_v_q <= VActEnd);
    tft_de  = h_act && v_act;
    pix_req = v_act && (cnt_h_q >= HReqStart) && (cnt_h_q <= HReqEnd);
    pix_x   = pix_req ? cnt_h_q - HReqStart : 10'h3FF;
    pix_y   = pix_req ? cnt_v_q - VActStart : 10'h3FF;
    rgb_tft = tft_de ? pix_data : 16'h0000;
    tft_clk = clk_9m;
    tft_bl  = sys_rst_n;
  end

endmodule

// File: tb/tb_tft_ctrl.sv
// Bench for tft_ctrl: one default-geometry instance and one shrunken-geometry instance (so whole
// frames and wraps fit in the run), each compared every cycle against a position-from-time model.
module tb_tft_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;

  initial forever #5 clk = ~clk;

  task automatic chk(input int inst, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL u%0d.%s: got %0h, expected %0h (t=%0t)", inst, name, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int HS = (gi == 0) ? 41  : 5;
    localparam int HB = 2;
    localparam int HV = (gi == 0) ? 480 : 16;
    localparam int HF = (gi == 0) ? 2   : 3;
    localparam int VS = (gi == 0) ? 10  : 3;
    localparam int VB = 2;
    localparam int VV = (gi == 0) ? 272 : 6;
    localparam int VF = 2;
    localparam int HT = HS + HB + HV + HF;
    localparam int VT = VS + VB + VV + VF;

    logic [9:0]  pix_x, pix_y;
    logic [15:0] pix_data, rgb_tft, salt, cap;
    logic        hsync, vsync, tft_clk, tft_de, tft_bl;
    int          n = 0;
    logic [15:0] exp_q[$];

    if (gi == 0) begin : g_default
      tft_ctrl u_dut (
        .clk_9m(clk), .sys_rst_n(rst_n), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
        .rgb_tft(rgb_tft), .hsync(hsync), .vsync(vsync), .tft_clk(tft_clk), .tft_de(tft_de),
        .tft_bl(tft_bl)
      );
    end else begin : g_small
      tft_ctrl #(
        .H_SYNC(10'(HS)), .H_BACK(10'(HB)), .H_VALID(10'(HV)), .H_FRONT(10'(HF)),
        .H_TOTAL(10'(HT)), .V_SYNC(10'(VS)), .V_BACK(10'(VB)), .V_VALID(10'(VV)),
        .V_FRONT(10'(VF)), .V_TOTAL(10'(VT))
      ) u_dut (
        .clk_9m(clk), .sys_rst_n(rst_n), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
        .rgb_tft(rgb_tft), .hsync(hsync), .vsync(vsync), .tft_clk(tft_clk), .tft_de(tft_de),
        .tft_bl(tft_bl)
      );
    end

    // Model state is just the number of clocks counted since reset.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        n = 0;
        exp_q.delete();
      end else begin
        n = n + 1;
      end
    end

    // Downstream pattern stage: registers the requested coordinates, scrambled by a random salt.
    initial begin
      pix_data = 16'h0000;
      salt     = 16'($urandom);
      forever begin
        @(negedge clk);
        cap = {pix_y[5:0], pix_x} ^ salt;
        @(posedge clk);
        #1;
        pix_data = cap;
        salt     = 16'($urandom);
      end
    end

    always @(negedge clk) begin : model
      int         h, v;
      logic       va, ha, req;
      logic [9:0] ex, ey;
      h   = n % HT;
      v   = (n / HT) % VT;
      va  = (v >= VS + VB) && (v < VS + VB + VV);
      ha  = (h >= HS + HB) && (h < HS + HB + HV);
      req = va && (h >= HS + HB - 1) && (h < HS + HB + HV - 1);
      ex  = req ? 10'(h - (HS + HB - 1)) : 10'h3FF;
      ey  = req ? 10'(v - (VS + VB)) : 10'h3FF;
      chk(gi, "hsync", 32'(hsync), 32'(h < HS));
      chk(gi, "vsync", 32'(vsync), 32'(v < VS));
      chk(gi, "tft_de", 32'(tft_de), 32'(ha && va));
      chk(gi, "pix_x", 32'(pix_x), 32'(ex));
      chk(gi, "pix_y", 32'(pix_y), 32'(ey));
      chk(gi, "tft_bl", 32'(tft_bl), 32'(rst_n));
      chk(gi, "tft_clk", 32'(tft_clk), 32'(clk));
      if (req) exp_q.push_back({ey[5:0], ex} ^ salt);
    end

    always @(negedge clk) begin : monitor
      logic [15:0] e;
      if (tft_de === 1'b1) begin
        chk(gi, "rgb_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk(gi, "rgb_active", 32'(rgb_tft), 32'(e));
        end
      end else begin
        chk(gi, "rgb_blank", 32'(rgb_tft), 32'd0);
      end
    end

    // Outputs must fall back to reset values without waiting for a clock edge.
    always @(negedge rst_n) begin
      #1;
      chk(gi, "async_hsync", 32'(hsync), 32'd1);
      chk(gi, "async_vsync", 32'(vsync), 32'd1);
      chk(gi, "async_de", 32'(tft_de), 32'd0);
      chk(gi, "async_pix_x", 32'(pix_x), 32'h3FF);
      chk(gi, "async_pix_y", 32'(pix_y), 32'h3FF);
      chk(gi, "async_rgb", 32'(rgb_tft), 32'd0);
      chk(gi, "async_bl", 32'(tft_bl), 32'd0);
    end
  end

  task automatic pulse_reset(input int hold);
    #2 rst_n = 1'b0;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    // Reset lands at cnt_v=100, cnt_h=300 of the default-geometry instance.
    repeat (100 * 525 + 300) @(posedge clk);
    pulse_reset(3);
    repeat (13 * 525 + $urandom_range(0, 524)) @(posedge clk);
    pulse_reset($urandom_range(1, 6));
    repeat (13 * 525) @(posedge clk);
    @(negedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
